// File: rtl/menu_navigator_if.sv
`default_nettype none
// ============================================================================
// Module      : menu_navigator_if
// Description : Control/status bundle between the menu front end and the
//               menu_navigator core. The master side drives the arrow keys,
//               field select and confirm/ack; the slave side is the core.
// Revision    : 1.0 - initial release
// ============================================================================
interface menu_navigator_if #(
  parameter int N_CAMPOS = 5,
  parameter int W        = 4
);
  localparam int SEL_W = $clog2(N_CAMPOS);

  logic                  right_arrow_pressed;
  logic                  left_arrow_pressed;
  logic                  load_initial;
  logic [SEL_W-1:0]      campo_sel;
  logic                  confirma;
  logic                  config_ack;
  logic [N_CAMPOS*W-1:0] valores;
  logic [N_CAMPOS*W-1:0] config_out;
  logic                  config_valid;
  logic                  alterado;
  logic [W-1:0]          arduino_out;

  modport master (
    output right_arrow_pressed, left_arrow_pressed, load_initial,
           campo_sel, confirma, config_ack,
    input  valores, config_out, config_valid, alterado, arduino_out
  );

  modport slave (
    input  right_arrow_pressed, left_arrow_pressed, load_initial,
           campo_sel, confirma, config_ack,
    output valores, config_out, config_valid, alterado, arduino_out
  );
endinterface
`default_nettype wire

// File: rtl/menu_navigator.sv
`default_nettype none
// ============================================================================
// Module      : menu_navigator
// Description : N-field menu configuration navigator. Arrow presses (with
//               auto-repeat) step the selected field, wrapping or saturating.
//               A confirm/ack handshake publishes a configuration snapshot and
//               the selected field is registered out for the Arduino link.
// Revision    : 1.0 - initial release
// ============================================================================
module menu_navigator #(
  parameter int                  N_CAMPOS     = 5,
  parameter int                  MAX_OPCOES   = 16,
  parameter logic [N_CAMPOS*5-1:0] OPCOES     = {5'd3, 5'd16, 5'd4, 5'd2, 5'd3},
  parameter int                  WRAP         = 1,
  parameter int                  REPEAT_DELAY = 25_000_000,
  parameter int                  REPEAT_RATE  = 5_000_000
) (
  input  wire logic           clock,
  input  wire logic           reset,
  menu_navigator_if.slave     bus
);
  localparam int W  = $clog2(MAX_OPCOES);
  localparam int NW = N_CAMPOS * W;

  logic          r_right_prev;
  logic          r_left_prev;
  logic          r_conf_prev;
  logic          r_armed;       // both arrows seen released since reset
  logic          r_rep_flag;    // first auto-repeat already fired
  logic [31:0]   r_hold_cnt;
  logic [NW-1:0] r_vals;
  logic [NW-1:0] r_cfg;
  logic          r_valid;
  logic          r_alt;
  logic [W-1:0]  r_ard;

  logic          w_right, w_left;
  logic          w_sel_ok, w_both, w_one_held, w_active;
  logic          w_edge_r, w_edge_l, w_edge;
  logic [31:0]   w_rep_target;
  logic          w_rep_hit;
  logic          w_do_r, w_do_l;
  logic          w_conf_edge;
  logic          w_changed;
  logic [NW-1:0] w_next_vals;
  logic [W-1:0]  w_sel_val;

  // Step right by one within a field of count c
  function automatic logic [W-1:0] f_inc(input logic [W-1:0] v, input logic [4:0] c);
    logic [W-1:0] last;
    last = W'(c - 5'd1);
    if (v == last) f_inc = (WRAP != 0) ? '0 : v;
    else           f_inc = v + 1'b1;
  endfunction

  // Step left by one within a field of count c
  function automatic logic [W-1:0] f_dec(input logic [W-1:0] v, input logic [4:0] c);
    logic [W-1:0] last;
    last = W'(c - 5'd1);
    if (v == '0) f_dec = (WRAP != 0) ? last : v;
    else         f_dec = v - 1'b1;
  endfunction

  assign w_right     = bus.right_arrow_pressed;
  assign w_left      = bus.left_arrow_pressed;
  assign w_sel_ok    = int'(bus.campo_sel) < N_CAMPOS;
  assign w_both      = w_right & w_left;
  assign w_one_held  = w_right ^ w_left;
  // A held arrow after reset is ignored until both arrows have been released
  assign w_active    = r_armed & w_sel_ok & ~w_both;
  assign w_edge_r    = w_right & ~r_right_prev;
  assign w_edge_l    = w_left & ~r_left_prev;
  assign w_edge      = w_edge_r | w_edge_l;
  assign w_rep_target = r_rep_flag ? 32'(REPEAT_RATE - 1) : 32'(REPEAT_DELAY - 1);
  assign w_rep_hit   = (REPEAT_DELAY != 0) && w_active && w_one_held && !w_edge &&
                       (r_hold_cnt == w_rep_target);
  assign w_do_r      = w_active & w_right & (w_edge_r | w_rep_hit);
  assign w_do_l      = w_active & w_left  & (w_edge_l | w_rep_hit);
  assign w_conf_edge = bus.confirma & ~r_conf_prev;
  assign w_changed   = (w_next_vals != r_vals);

  // Next field values after this cycle's step, and the selected field's value
  always_comb begin
    w_next_vals = r_vals;
    w_sel_val   = '0;
    for (int i = 0; i < N_CAMPOS; i++) begin
      if (int'(bus.campo_sel) == i) begin
        w_sel_val = r_vals[i*W +: W];
        if (w_do_r)      w_next_vals[i*W +: W] = f_inc(r_vals[i*W +: W], OPCOES[i*5 +: 5]);
        else if (w_do_l) w_next_vals[i*W +: W] = f_dec(r_vals[i*W +: W], OPCOES[i*5 +: 5]);
      end
    end
  end

  // Edge history, arming and the shared auto-repeat counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_right_prev <= 1'b0;
      r_left_prev  <= 1'b0;
      r_conf_prev  <= 1'b0;
      r_armed      <= 1'b0;
      r_rep_flag   <= 1'b0;
      r_hold_cnt   <= '0;
    end else begin
      r_right_prev <= w_right;
      r_left_prev  <= w_left;
      r_conf_prev  <= bus.confirma;
      if (!w_right && !w_left) r_armed <= 1'b1;
      if ((REPEAT_DELAY != 0) && w_active && w_one_held && !w_edge && !w_rep_hit)
        r_hold_cnt <= r_hold_cnt + 32'd1;
      else
        r_hold_cnt <= '0;
      if (!(w_active && w_one_held) || w_edge) r_rep_flag <= 1'b0;
      else if (w_rep_hit)                      r_rep_flag <= 1'b1;
    end
  end

  // Field values and the changed-since-confirm flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vals <= '0;
      r_alt  <= 1'b0;
    end else begin
      r_vals <= bus.load_initial ? '0 : w_next_vals;
      // A step landing in the confirm cycle is not in the snapshot, so it
      // keeps the flag set rather than being cleared by the confirm
      if ((bus.load_initial && (|r_vals)) || (!bus.load_initial && w_changed))
        r_alt <= 1'b1;
      else if (w_conf_edge)
        r_alt <= 1'b0;
    end
  end

  // Snapshot handshake: confirm edge wins over a same-cycle ack
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cfg   <= '0;
      r_valid <= 1'b0;
    end else if (w_conf_edge) begin
      r_cfg   <= r_vals;
      r_valid <= 1'b1;
    end else if (bus.config_ack) begin
      r_valid <= 1'b0;
    end
  end

  // Registered selected-field value for the Arduino link (0 if out of range)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_ard <= '0;
    else       r_ard <= w_sel_val;
  end

  assign bus.valores      = r_vals;
  assign bus.config_out   = r_cfg;
  assign bus.config_valid = r_valid;
  assign bus.alterado     = r_alt;
  assign bus.arduino_out  = r_ard;
endmodule
`default_nettype wire

// File: tb/tb_menu_navigator.sv
`default_nettype none
// ============================================================================
// Module      : tb_menu_navigator
// Description : Self-checking bench for menu_navigator. Instance A wraps and
//               auto-repeats (delay 10, rate 4); instance B saturates with
//               auto-repeat off. Both see the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_menu_navigator;
  localparam int N  = 5;
  localparam int W  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  menu_navigator_if #(.N_CAMPOS(N), .W(W)) bus_a ();
  menu_navigator_if #(.N_CAMPOS(N), .W(W)) bus_b ();

  menu_navigator #(.N_CAMPOS(N), .MAX_OPCOES(16), .WRAP(1),
                   .REPEAT_DELAY(10), .REPEAT_RATE(4)) u_dut_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  menu_navigator #(.N_CAMPOS(N), .MAX_OPCOES(16), .WRAP(0),
                   .REPEAT_DELAY(0), .REPEAT_RATE(1)) u_dut_b (
    .clock(clock), .reset(reset), .bus(bus_b));

  assign bus_b.right_arrow_pressed = bus_a.right_arrow_pressed;
  assign bus_b.left_arrow_pressed  = bus_a.left_arrow_pressed;
  assign bus_b.load_initial        = bus_a.load_initial;
  assign bus_b.campo_sel           = bus_a.campo_sel;
  assign bus_b.confirma            = bus_a.confirma;
  assign bus_b.config_ack          = bus_a.config_ack;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q_exp[$];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    q_exp.push_back(v);
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] obs);
    if (q_exp.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0h, no expected value queued", tag, obs);
    end else begin
      check_value(tag, obs, q_exp.pop_front());
    end
  endtask

  function automatic logic [31:0] fld(input logic [N*W-1:0] v, input int i);
    return 32'(v[i*W +: W]);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_a.right_arrow_pressed = 1'b0;
    bus_a.left_arrow_pressed  = 1'b0;
    bus_a.load_initial = 1'b0;
    bus_a.confirma     = 1'b0;
    bus_a.config_ack   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_r();
    bus_a.right_arrow_pressed = 1'b1; tick();
    bus_a.right_arrow_pressed = 1'b0; tick();
  endtask

  task automatic pulse_l();
    bus_a.left_arrow_pressed = 1'b1; tick();
    bus_a.left_arrow_pressed = 1'b0; tick();
  endtask

  task automatic pulse_confirm();
    bus_a.confirma = 1'b1; tick();
    bus_a.confirma = 1'b0; tick();
  endtask

  initial begin
    int changes[$];
    logic [31:0] prev, cur;
    int exp_edges[6] = '{0, 10, 14, 18, 22, 26};

    bus_a.campo_sel = '0;
    do_reset();
    reset = 1'b1;
    tick();
    sb_push(0); sb_pop("rst valores", 32'(bus_a.valores));
    sb_push(0); sb_pop("rst config_out", 32'(bus_a.config_out));
    sb_push(0); sb_pop("rst config_valid", 32'(bus_a.config_valid));
    sb_push(0); sb_pop("rst alterado", 32'(bus_a.alterado));
    sb_push(0); sb_pop("rst arduino_out", 32'(bus_a.arduino_out));
    reset = 1'b0;
    tick();

    // 17 right pulses on the 16-option field
    bus_a.campo_sel = 3'd3;
    repeat (16) pulse_r();
    bus_a.right_arrow_pressed = 1'b1;
    tick();
    sb_push(1);  sb_pop("wrap17 field3", fld(bus_a.valores, 3));
    sb_push(0);  sb_pop("wrap17 arduino lag", 32'(bus_a.arduino_out));
    bus_a.right_arrow_pressed = 1'b0;
    tick();
    sb_push(1);  sb_pop("wrap17 arduino", 32'(bus_a.arduino_out));
    sb_push(1);  sb_pop("wrap17 alterado", 32'(bus_a.alterado));
    sb_push(15); sb_pop("sat17 field3", fld(bus_b.valores, 3));

    // 3 right pulses on the 2-option field, then a left at 0
    do_reset();
    bus_a.campo_sel = 3'd1;
    repeat (3) pulse_r();
    sb_push(1); sb_pop("wrap field1", fld(bus_a.valores, 1));
    sb_push(1); sb_pop("sat field1", fld(bus_b.valores, 1));
    pulse_confirm();
    sb_push(0); sb_pop("sat alterado after confirm", 32'(bus_b.alterado));
    bus_a.campo_sel = 3'd0;
    pulse_l();
    sb_push(2); sb_pop("wrap left field0", fld(bus_a.valores, 0));
    sb_push(0); sb_pop("sat left field0", fld(bus_b.valores, 0));
    sb_push(0); sb_pop("sat left alterado", 32'(bus_b.alterado));
    sb_push(1); sb_pop("wrap left alterado", 32'(bus_a.alterado));

    // Auto-repeat: hold right 30 cycles on field 3
    do_reset();
    bus_a.campo_sel = 3'd3;
    prev = fld(bus_a.valores, 3);
    bus_a.right_arrow_pressed = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      cur = fld(bus_a.valores, 3);
      if (cur != prev) changes.push_back(c);
      prev = cur;
    end
    for (int i = 0; i < 6; i++) sb_push(32'(exp_edges[i]));
    for (int i = 0; i < 6; i++)
      sb_pop("repeat step edge", (i < changes.size()) ? 32'(changes[i]) : 32'hFFFF_FFFF);
    sb_push(6); sb_pop("repeat step count", 32'(changes.size()));
    sb_push(6); sb_pop("repeat final", fld(bus_a.valores, 3));
    sb_push(1); sb_pop("no-repeat final", fld(bus_b.valores, 3));
    bus_a.left_arrow_pressed = 1'b1;
    repeat (15) tick();
    sb_push(6); sb_pop("both held", fld(bus_a.valores, 3));
    bus_a.right_arrow_pressed = 1'b0;
    bus_a.left_arrow_pressed  = 1'b0;
    tick();

    // Build {0,15,3,1,2} and exercise the confirm handshake
    do_reset();
    bus_a.campo_sel = 3'd3; pulse_l();
    bus_a.campo_sel = 3'd2; pulse_l();
    bus_a.campo_sel = 3'd1; pulse_r();
    bus_a.campo_sel = 3'd0; pulse_l();
    sb_push(32'h0F312); sb_pop("built valores", 32'(bus_a.valores));
    bus_a.confirma = 1'b1;
    tick();
    sb_push(32'h0F312); sb_pop("confirm config_out", 32'(bus_a.config_out));
    sb_push(1); sb_pop("confirm valid", 32'(bus_a.config_valid));
    sb_push(0); sb_pop("confirm alterado", 32'(bus_a.alterado));
    bus_a.confirma = 1'b0;
    tick();
    bus_a.campo_sel = 3'd4; pulse_r();
    bus_a.confirma   = 1'b1;
    bus_a.config_ack = 1'b1;
    tick();
    sb_push(1); sb_pop("confirm+ack valid", 32'(bus_a.config_valid));
    sb_push(32'h1F312); sb_pop("confirm+ack config_out", 32'(bus_a.config_out));
    bus_a.confirma   = 1'b0;
    bus_a.config_ack = 1'b0;
    tick();
    bus_a.config_ack = 1'b1;
    tick();
    sb_push(0); sb_pop("ack valid", 32'(bus_a.config_valid));
    bus_a.config_ack = 1'b0;
    tick();
    sb_push(32'h1F312); sb_pop("ack config_out held", 32'(bus_a.config_out));
    bus_a.load_initial = 1'b1;
    tick();
    bus_a.load_initial = 1'b0;
    sb_push(0); sb_pop("load valores", 32'(bus_a.valores));
    sb_push(1); sb_pop("load alterado", 32'(bus_a.alterado));
    sb_push(32'h1F312); sb_pop("load config_out", 32'(bus_a.config_out));
    sb_push(0); sb_pop("load valid", 32'(bus_a.config_valid));

    // Out-of-range select, then load_initial with a step
    bus_a.campo_sel = 3'd3; pulse_r();
    sb_push(1); sb_pop("sel3 arduino", 32'(bus_a.arduino_out));
    bus_a.campo_sel = 3'd6; pulse_r();
    sb_push(32'h01000); sb_pop("sel6 valores", 32'(bus_a.valores));
    sb_push(0); sb_pop("sel6 arduino", 32'(bus_a.arduino_out));
    bus_a.campo_sel = 3'd3;
    bus_a.right_arrow_pressed = 1'b1;
    bus_a.load_initial = 1'b1;
    tick();
    bus_a.right_arrow_pressed = 1'b0;
    bus_a.load_initial = 1'b0;
    sb_push(0); sb_pop("load+step valores", 32'(bus_a.valores));
    tick();

    // Reset mid-repeat with a pending snapshot
    do_reset();
    bus_a.campo_sel = 3'd3; pulse_r();
    pulse_confirm();
    bus_a.right_arrow_pressed = 1'b1;
    repeat (12) tick();
    sb_push(3); sb_pop("pre-reset field3", fld(bus_a.valores, 3));
    sb_push(1); sb_pop("pre-reset valid", 32'(bus_a.config_valid));
    reset = 1'b1;
    #2;
    sb_push(0); sb_pop("midrst valores", 32'(bus_a.valores));
    sb_push(0); sb_pop("midrst config_out", 32'(bus_a.config_out));
    sb_push(0); sb_pop("midrst valid", 32'(bus_a.config_valid));
    sb_push(0); sb_pop("midrst alterado", 32'(bus_a.alterado));
    sb_push(0); sb_pop("midrst arduino", 32'(bus_a.arduino_out));
    tick();
    reset = 1'b0;
    repeat (15) tick();
    sb_push(0); sb_pop("held after reset", fld(bus_a.valores, 3));
    bus_a.right_arrow_pressed = 1'b0;
    tick();
    bus_a.right_arrow_pressed = 1'b1;
    tick();
    sb_push(1); sb_pop("repress after reset", fld(bus_a.valores, 3));
    bus_a.right_arrow_pressed = 1'b0;
    tick();

    if (q_exp.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard drain: got %0d leftover, expected 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/menu_navigator.md
# menu_navigator

Parametrised menu-configuration navigator for the game front end. It holds N independent option fields, each with its own option count. Left/right arrow presses step only the currently selected field, either wrapping or saturating at the ends, and a held arrow auto-repeats. A confirm/acknowledge handshake publishes a stable configuration snapshot to the game FSM. The selected field's value is registered out as a binary index for the Arduino link.

## Interface
- `N_CAMPOS`, 5, number of option fields.
- `MAX_OPCOES`, 16, upper bound on any field's option count; `W = $clog2(MAX_OPCOES)` (4).
- `OPCOES`, {5'd3,5'd16,5'd4,5'd2,5'd3}, packed 5-bit option counts; field i count at [i*5 +: 5]; each count is 1..MAX_OPCOES.
- `WRAP`, 1, 1 = wrap at the ends, 0 = saturate.
- `REPEAT_DELAY`, 25_000_000, held cycles before the first auto-repeat; 0 disables auto-repeat.
- `REPEAT_RATE`, 5_000_000, cycles between later repeats; must be ≥1.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `right_arrow_pressed` input 1: level, synchronous to `clock`.
- `left_arrow_pressed` input 1: level, synchronous to `clock`.
- `load_initial` input 1: synchronous; all fields return to 0.
- `campo_sel` input $clog2(N_CAMPOS): field being edited.
- `confirma` input 1: level; its rising edge requests a snapshot.
- `config_ack` input 1: consumer has taken the snapshot.
- `valores` output N_CAMPOS*W: live field values; field i at [i*W +: W].
- `config_out` output N_CAMPOS*W: snapshot of `valores` taken at confirm.
- `config_valid` output 1: snapshot pending acknowledgement.
- `alterado` output 1: a field changed since the last confirm.
- `arduino_out` output W: registered value of the selected field.

## Operation
- **Arrow edge detection.** Each arrow input has its own previous-sample register.
  - step_r = right & ~right_prev.
  - step_l = left & ~left_prev.
- **Auto-repeat.**
  - One hold counter is shared. It clears on any edge step or when the held arrow is released.
  - It increments each cycle while exactly one arrow is held.
  - A repeat step fires when the counter reaches REPEAT_DELAY-1 (first repeat) or REPEAT_RATE-1 (later repeats); the counter then clears.
  - A one-bit flag records whether the first repeat has occurred; it clears on release.
- **Step application.** A step changes only field `campo_sel`, with count C.
  - Right: v+1. At v = C-1 the result is 0 if WRAP=1, or unchanged if WRAP=0.
  - Left: v-1. At v = 0 the result is C-1 if WRAP=1, or unchanged if WRAP=0.
  - C = 1: the field stays 0.
- **Ignored conditions (no change, counter cleared):**
  - both arrows high at once;
  - `campo_sel` ≥ N_CAMPOS; in this case `arduino_out` is 0.
- **Priority:** reset > load_initial > step. `load_initial` and a step in the same cycle resolve to all fields 0.
- **alterado:**
  - Set when a step actually changes a value (a saturated no-op does not set it).
  - Set by `load_initial` if any field was nonzero.
  - Cleared on a confirm edge.
- **Confirm handshake:**
  - A rising edge of `confirma` latches `config_out` ← `valores` (value before this cycle's step) and sets `config_valid`.
  - `config_ack` while valid clears `config_valid`; `config_out` holds its value.
  - Confirm and ack in the same cycle: confirm wins, so `config_valid` stays 1 with the new snapshot.
  - Confirm while already valid re-snapshots; valid stays 1.
  - `load_initial` does not touch `config_out` or `config_valid`.

## Timing
- **Reset values:**
  - `valores`, `config_out` and `arduino_out` are all 0.
  - `config_valid`, `alterado`, the edge registers, the hold counter and the repeat flag are all 0.
- **Step latency:**
  - A field updates on the edge at which the arrow is first sampled high, so `valores` shows the new value in the next cycle.
  - `arduino_out` lags `valores` and `campo_sel` by one cycle.
- **Auto-repeat timing.** With the first step at edge k and the arrow held:
  - the first repeat occurs at edge k+REPEAT_DELAY;
  - later repeats occur every REPEAT_RATE edges after that.
- **Confirm timing:** `config_valid` and `config_out` become visible the cycle after the `confirma` rising edge. An ack clears valid on the next edge.
- **Reset mid-operation** (e.g. during a hold or a pending snapshot) returns everything to the reset values immediately, and a still-held arrow produces no step until it is released and pressed again.

## Test plan
- Reset, then `campo_sel`=3 (count 16) and 17 single right pulses (WRAP=1) → field 3 reads 1, `alterado`=1, `arduino_out`=1 one cycle after `valores`.
- WRAP=0, `campo_sel`=1 (count 2): 3 right pulses → field 1 = 1. A left pulse at 0 on field 0 → stays 0, `alterado` unchanged.
- REPEAT_DELAY=10, REPEAT_RATE=4: hold right for 30 cycles on field 3 from 0 → steps at edges k, k+10, k+14, k+18, k+22, k+26, final value 6. Both arrows held → no change.
- Confirm after field values {0,15,3,1,2} → `config_out` equals `valores`, valid=1, `alterado`=0. Confirm+ack in the same cycle → valid stays 1. Ack alone → valid 0, `config_out` held.
- `campo_sel`=6 plus a right pulse → no field changes, `arduino_out`=0. `load_initial` together with a step → all fields 0.
- Assert reset while held mid-repeat with valid=1 → all outputs 0. Keep the arrow held after reset deasserts → no step until it is released and pressed again.
